// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared defines, opcodes and state encoding for the MEM-stage data-bus controller.
// Optional build macro: DBUS_KSEG_MAP_EN folds kseg0/kseg1 addresses onto physical space.
`ifndef MEM_DBUS_DEFINES
`define MEM_DBUS_DEFINES
`define ALUOP_BUS 7:0
`define BSEL_BUS 3:0
`define STALL_BUS 5:0
`define NOSTOP 1'b0
`define STOP 1'b1
`define ZERO_WORD 32'h0000_0000
`endif

package mem_dbus_ctrl_pkg;

  localparam logic [7:0] OP_LB  = 8'h90;
  localparam logic [7:0] OP_LBU = 8'h91;
  localparam logic [7:0] OP_LH  = 8'h92;
  localparam logic [7:0] OP_LHU = 8'h93;
  localparam logic [7:0] OP_LW  = 8'h94;
  localparam logic [7:0] OP_SB  = 8'h98;
  localparam logic [7:0] OP_SH  = 8'h99;
  localparam logic [7:0] OP_SW  = 8'h9A;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_CANCEL = 3'd4
  } dbus_state_e;

endpackage

// File: rtl/mem_lane_gen.sv
// Combinational size / byte-select / store-lane generator for the data bus.
module mem_lane_gen
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [`ALUOP_BUS]  aluop,
  input  logic [1:0]         addr_lo,
  input  logic [DATA_W-1:0]  wdata,
  output logic               is_mem,
  output logic               is_store,
  output logic [1:0]         size,
  output logic [`BSEL_BUS]   dre,
  output logic [DATA_W-1:0]  wdata_o
);

  always_comb begin
    is_mem   = 1'b1;
    is_store = 1'b0;
    size     = SZ_WORD;
    dre      = '0;
    wdata_o  = wdata;
    case (aluop)
      OP_LB, OP_LBU: size = SZ_BYTE;
      OP_LH, OP_LHU: size = SZ_HALF;
      OP_LW:         size = SZ_WORD;
      OP_SB: begin
        size     = SZ_BYTE;
        is_store = 1'b1;
      end
      OP_SH: begin
        size     = SZ_HALF;
        is_store = 1'b1;
      end
      OP_SW:   is_store = 1'b1;
      default: is_mem = 1'b0;
    endcase
    if (is_mem) begin
      case (size)
        SZ_BYTE: begin
          dre     = 4'b0001 << addr_lo;
          wdata_o = {(DATA_W/8){wdata[7:0]}};
        end
        SZ_HALF: begin
          dre     = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_o = {(DATA_W/16){wdata[15:0]}};
        end
        default: dre = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: one bus transaction per load/store, stalls until done.
// Optional build macro: DBUS_KSEG_MAP_EN (kseg0/kseg1 -> physical address folding).
module mem_dbus_ctrl
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic [`ALUOP_BUS]  mem_aluop,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_exc,
  input  logic               flush,
  input  logic [`STALL_BUS]  stall,
  output logic               stallreq_mem,
  output logic [`BSEL_BUS]   mem_dre,
  output logic [DATA_W-1:0]  dm_o,
  output logic               data_req,
  output logic               data_wr,
  output logic [1:0]         data_size,
  output logic [ADDR_W-1:0]  data_addr,
  output logic [DATA_W-1:0]  data_wdata,
  input  logic               data_addr_ok,
  input  logic [DATA_W-1:0]  data_rdata,
  input  logic               data_data_ok
);

  dbus_state_e       state_q, state_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
  logic              is_mem;
  logic              acc;
  logic              stall_unused;

  assign stall_unused = ^{stall[5], stall[3:0]};

  mem_lane_gen #(.DATA_W(DATA_W)) u_lane (
    .aluop    (mem_aluop),
    .addr_lo  (mem_addr[1:0]),
    .wdata    (mem_wdata),
    .is_mem   (is_mem),
    .is_store (data_wr),
    .size     (data_size),
    .dre      (mem_dre),
    .wdata_o  (data_wdata)
  );

  assign acc = is_mem && !mem_exc;

`ifdef DBUS_KSEG_MAP_EN
  always_comb begin
    data_addr = mem_addr;
    if (mem_addr[ADDR_W-1 -: 2] == 2'b10)
      data_addr = {3'b000, mem_addr[ADDR_W-4:0]};
  end
`else
  assign data_addr = mem_addr;
`endif

  always_comb begin
    state_d      = state_q;
    rdata_buf_d  = rdata_buf_q;
    data_req     = 1'b0;
    stallreq_mem = 1'b0;
    dm_o         = rdata_buf_q;
    unique case (state_q)
      S_IDLE, S_REQ: begin
        data_req     = acc && !flush;
        stallreq_mem = acc;
        if (data_req && data_addr_ok)
          state_d = S_WAIT;
        else if (data_req)
          state_d = S_REQ;
        else
          state_d = S_IDLE;
      end
      S_WAIT: begin
        stallreq_mem = acc && !data_data_ok;
        if (data_data_ok) begin
          rdata_buf_d = data_rdata;
          dm_o        = data_rdata;
          state_d     = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d = S_CANCEL;
        end
      end
      S_DONE: begin
        if (stall[4] == `NOSTOP || flush)
          state_d = S_IDLE;
      end
      // Orphaned response: keep the pipe stalled and throw the data away.
      S_CANCEL: begin
        stallreq_mem = acc;
        if (data_data_ok)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q     <= S_IDLE;
      rdata_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Self-checking bench for mem_dbus_ctrl: lane table, directed corner sequences, random vs model.
module tb_mem_dbus_ctrl;
  import mem_dbus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_exc, flush;
  logic [5:0]  stall;
  logic        stallreq_mem;
  logic [3:0]  mem_dre;
  logic [31:0] dm_o;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  mem_dbus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .cpu_clk_50M  (clk),
    .cpu_rst      (cpu_rst),
    .mem_aluop    (mem_aluop),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_exc      (mem_exc),
    .flush        (flush),
    .stall        (stall),
    .stallreq_mem (stallreq_mem),
    .mem_dre      (mem_dre),
    .dm_o         (dm_o),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic aok,
                       input logic dok, input logic [31:0] rd);
    mem_aluop    = op;
    mem_addr     = a;
    mem_wdata    = wd;
    data_addr_ok = aok;
    data_data_ok = dok;
    data_rdata   = rd;
    #1;
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1;
    drive(8'h00, 0, 0, 0, 0, 0);
    tick();
    tick();
    cpu_rst = 1'b0;
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef DBUS_KSEG_MAP_EN
    if (a[31:29] == 3'b100 || a[31:29] == 3'b101)
      return a & 32'h1FFF_FFFF;
`endif
    return a;
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
                      OP_SB, OP_SH, OP_SW};
  endfunction

  task automatic lane_ref(input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] wd, output logic [1:0] sz,
                          output logic [3:0] dre, output logic [31:0] wo,
                          output logic wr);
    logic [31:0] one;
    one = 32'd1;
    wr  = op inside {OP_SB, OP_SH, OP_SW};
    if (op inside {OP_LB, OP_LBU, OP_SB}) begin
      sz  = 2'd0;
      dre = 4'((one << a[1:0]));
      wo  = wd[7:0] * 32'h0101_0101;
    end else if (op inside {OP_LH, OP_LHU, OP_SH}) begin
      sz  = 2'd1;
      dre = 4'((32'd3 << (2 * a[1])));
      wo  = wd[15:0] * 32'h0001_0001;
    end else begin
      sz  = 2'd2;
      dre = is_mem_op(op) ? 4'hF : 4'h0;
      wo  = wd;
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exc;
    logic [1:0]  sz;
    logic [3:0]  dre;
    logic [31:0] wdo;
    logic        wr;
    logic        req;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hs;
    int outstanding;
    bit orphan, done;
    logic [31:0] held;
    logic [7:0] ops[9];
    logic e_req, e_st, acc, aok, dok, adv;
    logic [31:0] e_dm, rd, a, wd, r_wo;
    logic [1:0] r_sz;
    logic [3:0] r_dre;
    logic r_wr;
    logic [7:0] op;

    vecs[0] = '{OP_SB,  32'h3,   32'h5A,       0, 0, 4'b1000, 32'h5A5A5A5A, 1, 1};
    vecs[1] = '{OP_LB,  32'h101, 32'h11223344, 0, 0, 4'b0010, 32'h44444444, 0, 1};
    vecs[2] = '{OP_LBU, 32'h2,   32'h11223344, 0, 0, 4'b0100, 32'h44444444, 0, 1};
    vecs[3] = '{OP_LH,  32'h2,   32'h11223344, 0, 1, 4'b1100, 32'h33443344, 0, 1};
    vecs[4] = '{OP_LHU, 32'h0,   32'h11223344, 0, 1, 4'b0011, 32'h33443344, 0, 1};
    vecs[5] = '{OP_SH,  32'h20,  32'h0000ABCD, 0, 1, 4'b0011, 32'hABCDABCD, 1, 1};
    vecs[6] = '{OP_LW,  32'h10,  32'h11223344, 0, 2, 4'b1111, 32'h11223344, 0, 1};
    vecs[7] = '{OP_SW,  32'h44,  32'hCAFEF00D, 0, 2, 4'b1111, 32'hCAFEF00D, 1, 1};
    vecs[8] = '{OP_LW,  32'h48,  32'h0,        1, 2, 4'b1111, 32'h0,        0, 0};
    vecs[9] = '{8'h00,  32'h48,  32'h0,        0, 2, 4'b0000, 32'h0,        0, 0};

    mem_exc = 0;
    flush   = 0;
    stall   = '0;
    do_reset();

    // Reset state
    drive(8'h00, 0, 0, 0, 0, 0);
    chk("rst_req", data_req, 0);
    chk("rst_stall", stallreq_mem, 0);
    chk("rst_dm", dm_o, 0);
    chk("rst_dre", mem_dre, 0);

    // LW with addr_ok same cycle, data_ok two cycles later
    drive(OP_LW, 32'h10, 0, 1, 0, 0);
    chk("lw_req", data_req, 1);
    chk("lw_stall0", stallreq_mem, 1);
    chk("lw_dre", mem_dre, 4'hF);
    chk("lw_addr", data_addr, 32'h10);
    chk("lw_wr", data_wr, 0);
    tick();
    drive(OP_LW, 32'h10, 0, 0, 0, 0);
    chk("lw_stall1", stallreq_mem, 1);
    chk("lw_req_wait", data_req, 0);
    tick();
    drive(OP_LW, 32'h10, 0, 0, 1, 32'hDEADBEEF);
    chk("lw_stall2", stallreq_mem, 0);
    chk("lw_dm_fwd", dm_o, 32'hDEADBEEF);
    tick();
    drive(8'h00, 0, 0, 0, 0, 0);
    chk("lw_dm_hold", dm_o, 32'hDEADBEEF);
    chk("lw_done_req", data_req, 0);
    tick();

    // Lane / request table
    for (int i = 0; i < 10; i++) begin
      mem_exc = vecs[i].exc;
      drive(vecs[i].op, vecs[i].addr, vecs[i].wd, 0, 0, 0);
      chk($sformatf("tbl%0d_req", i), data_req, vecs[i].req);
      chk($sformatf("tbl%0d_dre", i), mem_dre, vecs[i].dre);
      if (is_mem_op(vecs[i].op)) begin
        chk($sformatf("tbl%0d_size", i), data_size, vecs[i].sz);
        chk($sformatf("tbl%0d_wdata", i), data_wdata, vecs[i].wdo);
        chk($sformatf("tbl%0d_wr", i), data_wr, vecs[i].wr);
        chk($sformatf("tbl%0d_addr", i), data_addr, vecs[i].addr);
      end
      tick();
    end
    mem_exc = 0;
    do_reset();

    // addr_ok held low 3 cycles: one transaction only
    hs = 0;
    for (int i = 0; i < 3; i++) begin
      drive(OP_SW, 32'h80, 32'h11, 0, 0, 0);
      chk("hold_req", data_req, 1);
      chk("hold_addr", data_addr, 32'h80);
      chk("hold_stall", stallreq_mem, 1);
      if (data_req && data_addr_ok) hs++;
      tick();
    end
    drive(OP_SW, 32'h80, 32'h11, 1, 0, 0);
    chk("hold_req_ok", data_req, 1);
    if (data_req && data_addr_ok) hs++;
    tick();
    drive(OP_SW, 32'h80, 32'h11, 1, 0, 0);
    if (data_req && data_addr_ok) hs++;
    chk("sw_wait_stall", stallreq_mem, 1);
    tick();
    drive(OP_SW, 32'h80, 32'h11, 0, 1, 32'h0000_5555);
    chk("sw_ok_stall", stallreq_mem, 0);
    tick();
    drive(8'h00, 0, 0, 0, 0, 0);
    tick();
    chk("hold_handshakes", hs, 1);

    // Flush in WAIT -> drain orphaned response, then a clean LW
    drive(OP_LW, 32'h100, 0, 1, 0, 0);
    tick();
    flush = 1;
    drive(OP_LW, 32'h100, 0, 0, 0, 0);
    chk("fl_req", data_req, 0);
    tick();
    flush = 0;
    drive(OP_LW, 32'h104, 0, 1, 0, 0);
    chk("cancel_req", data_req, 0);
    chk("cancel_stall", stallreq_mem, 1);
    tick();
    drive(OP_LW, 32'h104, 0, 1, 1, 32'hBAD0BAD0);
    chk("cancel_req2", data_req, 0);
    chk("cancel_stall2", stallreq_mem, 1);
    chk("cancel_dm", dm_o, 32'h0000_5555);
    tick();
    drive(OP_LW, 32'h104, 0, 1, 0, 0);
    chk("post_req", data_req, 1);
    tick();
    drive(OP_LW, 32'h104, 0, 0, 1, 32'h12345678);
    chk("post_dm", dm_o, 32'h12345678);
    chk("post_stall", stallreq_mem, 0);
    tick();
    drive(8'h00, 0, 0, 0, 0, 0);
    chk("post_dm_hold", dm_o, 32'h12345678);
    tick();

    // DONE held while stall[4] = STOP
    stall[4] = 1'b1;
    drive(OP_LW, 32'h200, 0, 1, 0, 0);
    tick();
    drive(OP_LW, 32'h200, 0, 0, 1, 32'hA5A5A5A5);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(OP_LW, 32'h200, 0, 1, 1, 32'hFFFFFFFF);
      chk("done_dm", dm_o, 32'hA5A5A5A5);
      chk("done_stall", stallreq_mem, 0);
      chk("done_req", data_req, 0);
      tick();
    end
    stall[4] = 1'b0;
    drive(OP_LW, 32'h200, 0, 0, 0, 0);
    chk("done_req_last", data_req, 0);
    tick();
    drive(OP_LW, 32'h204, 0, 1, 0, 0);
    chk("done_exit_req", data_req, 1);
    tick();

    // Reset mid-WAIT
    cpu_rst = 1;
    tick();
    cpu_rst = 0;
    drive(OP_LW, 32'h204, 0, 0, 0, 0);
    chk("rstwait_req", data_req, 1);
    chk("rstwait_dm", dm_o, 0);
    drive(OP_LW, 32'hBFC0_0004, 0, 0, 0, 0);
    chk("kseg_addr", data_addr, exp_addr(32'hBFC0_0004));
    drive(8'h00, 0, 0, 0, 0, 0);
    tick();

    // Randomized run against the transaction-level model
    do_reset();
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 8'h00};
    outstanding = 0;
    orphan = 0;
    done = 0;
    held = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      op  = ops[$urandom_range(0, 8)];
      a   = $urandom;
      wd  = $urandom;
      rd  = $urandom;
      aok = 1'($urandom_range(0, 1));
      dok = ($urandom_range(0, 9) < 4);
      adv = ($urandom_range(0, 9) >= 3);
      mem_exc  = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      stall[4] = !adv;
      drive(op, a, wd, aok, dok, rd);

      acc = is_mem_op(op) && !mem_exc;
      e_dm = held;
      if (done) begin
        e_req = 0;
        e_st  = 0;
      end else if (outstanding != 0) begin
        e_req = 0;
        if (orphan) begin
          e_st = acc;
        end else begin
          e_st = acc && !dok;
          if (dok) e_dm = rd;
        end
      end else begin
        e_req = acc && !flush;
        e_st  = acc;
      end

      lane_ref(op, a, wd, r_sz, r_dre, r_wo, r_wr);
      chk("rnd_req", data_req, e_req);
      chk("rnd_stall", stallreq_mem, e_st);
      chk("rnd_dm", dm_o, e_dm);
      chk("rnd_dre", mem_dre, r_dre);
      if (is_mem_op(op)) begin
        chk("rnd_size", data_size, r_sz);
        chk("rnd_wdata", data_wdata, r_wo);
        chk("rnd_wr", data_wr, r_wr);
        chk("rnd_addr", data_addr, exp_addr(a));
      end

      if (outstanding != 0) begin
        if (dok) begin
          outstanding = 0;
          if (!orphan) begin
            held = rd;
            done = !flush;
          end
        end else if (flush) begin
          orphan = 1;
        end
      end else if (done) begin
        if (adv || flush) done = 0;
      end else if (e_req && aok) begin
        outstanding = 1;
        orphan = 0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
